quant_pipe: RTL and testbench

QUANT_PIPE -- requirements
Module: quant_pipe

---
 rtl/quant_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_quant_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_pipe.sv
// quant_pipe: two-stage JPEG coefficient quantiser, one block row (LANES
// coefficients) per beat. Stage 1 multiplies each coefficient by the
// reciprocal of its quantiser step; stage 2 rounds half away from zero,
// drops the fixed-point fraction and saturates to OUT_W bits.

// One lane: multiply register followed by round/saturate register.
module quant_lane #(
    parameter int IN_W      = 32,
    parameter int RECIP_W   = 17,
    parameter int FRAC_BITS = 16,
    parameter int OUT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_en,
    input  logic [IN_W-1:0]    i_x,
    input  logic [RECIP_W-1:0] i_recip,
    output logic [OUT_W-1:0]   o_q,
    output logic               o_sat
);
    // Product width: signed x times unsigned R, plus a sign bit.
    localparam int PW = IN_W + RECIP_W + 1;
    // Total fraction in the product: input fraction plus the 2^16 reciprocal scale.
    localparam int S  = FRAC_BITS + 16;

    localparam logic [PW-1:0]    ONE_P   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    HALF    = ONE_P << (S - 1);
    localparam logic [PW-1:0]    POS_LIM = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [PW-1:0]    NEG_LIM = POS_LIM + ONE_P;
    localparam logic [OUT_W-1:0] ONE_Q   = {{(OUT_W-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] Q_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] Q_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PW-1:0]    w_x_ext;
    logic [PW-1:0]    w_r_ext;
    logic [PW-1:0]    w_prod;
    logic [PW-1:0]    r_prod;
    logic             w_neg;
    logic [PW-1:0]    w_mag;
    logic [PW-1:0]    w_rnd;
    logic [PW-1:0]    w_qmag;
    logic [OUT_W-1:0] w_q;
    logic             w_sat;
    logic [OUT_W-1:0] r_q;
    logic             r_sat;

    // Both operands extended to the full product width, so the low PW bits
    // of an unsigned multiply are the exact two's-complement product.
    assign w_x_ext = {{(PW-IN_W){i_x[IN_W-1]}}, i_x};
    assign w_r_ext = {{(PW-RECIP_W){1'b0}}, i_recip};
    assign w_prod  = w_x_ext * w_r_ext;

    // Rounding is applied to the magnitude so ties move away from zero.
    assign w_neg  = r_prod[PW-1];
    assign w_mag  = w_neg ? (~r_prod + ONE_P) : r_prod;
    assign w_rnd  = w_mag + HALF;
    assign w_qmag = w_rnd >> S;

    // Saturate the rounded magnitude against the signed output range.
    always_comb begin
        w_q   = '0;
        w_sat = 1'b0;
        if (!w_neg) begin
            if (w_qmag > POS_LIM) begin
                w_q   = Q_MAX;
                w_sat = 1'b1;
            end else begin
                w_q = w_qmag[OUT_W-1:0];
            end
        end else begin
            if (w_qmag > NEG_LIM) begin
                w_q   = Q_MIN;
                w_sat = 1'b1;
            end else begin
                w_q = ~w_qmag[OUT_W-1:0] + ONE_Q;
            end
        end
    end

    // Both stages advance together with the rest of the pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prod <= '0;
            r_q    <= '0;
            r_sat  <= 1'b0;
        end else if (i_en) begin
            r_prod <= w_prod;
            r_q    <= w_q;
            r_sat  <= w_sat;
        end
    end

    assign o_q   = r_q;
    assign o_sat = r_sat;
endmodule

module quant_pipe #(
    parameter int LANES     = 8,
    parameter int IN_W      = 32,
    parameter int FRAC_BITS = 16,
    parameter int OUT_W     = 16,
    parameter int RECIP_W   = 17
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*IN_W-1:0]  data_in_i,
    input  logic                   tbl_sel_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*OUT_W-1:0] data_out_o,
    output logic [2:0]             out_row_o,
    output logic                   out_last_o,
    output logic [LANES-1:0]       sat_o,
    input  logic                   cfg_we_i,
    input  logic                   cfg_tbl_i,
    input  logic [5:0]             cfg_addr_i,
    input  logic [RECIP_W-1:0]     cfg_data_i
);
    localparam int STAGES = 2;

    // JPEG Annex K quantiser steps, row-major {row, col}.
    localparam int LUMA_Q [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };
    localparam int CHROMA_Q [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    // round(2^16 / q), evaluated on constants only.
    function automatic logic [RECIP_W-1:0] recip_of(input int q);
        return RECIP_W'((65536 + q / 2) / q);
    endfunction

    logic [RECIP_W-1:0]              r_tbl [2][64];
    logic [STAGES:1]                 r_vld_pipe;
    logic [2:0]                      r_row;
    logic                            r_tbl_sel;
    logic [2:0]                      r_row_s1;
    logic [2:0]                      r_row_s2;
    logic                            w_adv;
    logic                            w_accept;
    logic                            w_tbl_use;
    logic [LANES-1:0][RECIP_W-1:0]   w_recip;
    logic [LANES-1:0][OUT_W-1:0]     w_q;
    logic [LANES-1:0]                w_sat;

    // The whole pipeline moves only when the output slot is free or draining.
    assign w_adv      = !r_vld_pipe[STAGES] || out_ready_i;
    assign w_accept   = in_valid_i && w_adv;
    assign in_ready_o = w_adv;

    // Row 0 takes the live select; the rest of the block uses the latched one.
    assign w_tbl_use = (r_row == 3'd0) ? tbl_sel_i : r_tbl_sel;

    // Reciprocal table: reset loads Annex K, writes land at the clock edge so a
    // row looked up in the same cycle still sees the old entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 64; i++) begin
                r_tbl[0][i] <= recip_of(LUMA_Q[i]);
                r_tbl[1][i] <= recip_of(CHROMA_Q[i]);
            end
        end else if (cfg_we_i) begin
            r_tbl[cfg_tbl_i][cfg_addr_i] <= cfg_data_i;
        end
    end

    // Lane k of row r reads entry {r, k}.
    always_comb begin
        w_recip = '0;
        for (int k = 0; k < LANES; k++) begin
            w_recip[k] = r_tbl[w_tbl_use][{r_row, 3'(k)}];
        end
    end

    // Row counter and block table select, stepped by accepted rows only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_row     <= 3'd0;
            r_tbl_sel <= 1'b0;
        end else if (w_accept) begin
            r_row <= r_row + 3'd1;
            if (r_row == 3'd0) begin
                r_tbl_sel <= tbl_sel_i;
            end
        end
    end

    // Valid bits and row tags travel alongside the lane data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_pipe <= '0;
            r_row_s1   <= 3'd0;
            r_row_s2   <= 3'd0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid_i};
            r_row_s1   <= r_row;
            r_row_s2   <= r_row_s1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        quant_lane #(
            .IN_W      (IN_W),
            .RECIP_W   (RECIP_W),
            .FRAC_BITS (FRAC_BITS),
            .OUT_W     (OUT_W)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_en    (w_adv),
            .i_x     (data_in_i[k*IN_W +: IN_W]),
            .i_recip (w_recip[k]),
            .o_q     (w_q[k]),
            .o_sat   (w_sat[k])
        );
    end

    assign out_valid_o = r_vld_pipe[STAGES];
    assign data_out_o  = w_q;
    assign sat_o       = w_sat;
    assign out_row_o   = r_row_s2;
    assign out_last_o  = (r_row_s2 == 3'd7);
endmodule

// File: tb/tb_quant_pipe.sv
`timescale 1ns/1ps
module tb_quant_pipe;
    localparam int LANES = 8, IN_W = 32, OUT_W = 16, RECIP_W = 17;
    localparam int DW = LANES * IN_W, QW = LANES * OUT_W;
    localparam int F = 65536;

    logic clk_i = 1'b0;
    logic rst_i, in_valid_i, in_ready_o, tbl_sel_i, out_valid_o, out_ready_i;
    logic out_last_o, cfg_we_i, cfg_tbl_i;
    logic [DW-1:0] data_in_i;
    logic [QW-1:0] data_out_o;
    logic [2:0] out_row_o;
    logic [LANES-1:0] sat_o;
    logic [5:0] cfg_addr_i;
    logic [RECIP_W-1:0] cfg_data_i;

    quant_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_in_i(data_in_i), .tbl_sel_i(tbl_sel_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .data_out_o(data_out_o), .out_row_o(out_row_o),
        .out_last_o(out_last_o), .sat_o(sat_o), .cfg_we_i(cfg_we_i), .cfg_tbl_i(cfg_tbl_i),
        .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [QW-1:0]    data;
        logic [2:0]       row;
        logic [LANES-1:0] sat;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_err = 0;

    // Column-0 luma steps per row; row r feeds Q*(r+1) so it quantises to r+1.
    int q_col0 [8] = '{16, 12, 14, 14, 18, 24, 49, 72};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] xin(input logic [DW-1:0] b, input int l, input int v);
        b[l*IN_W +: IN_W] = 32'(v);
        return b;
    endfunction

    function automatic logic [QW-1:0] qv(input logic [QW-1:0] b, input int l, input int v);
        b[l*OUT_W +: OUT_W] = 16'(v);
        return b;
    endfunction

    function automatic exp_t mk(input logic [QW-1:0] d, input int row, input logic [LANES-1:0] s);
        exp_t e;
        e.data = d;
        e.row  = 3'(row);
        e.sat  = s;
        return e;
    endfunction

    // Monitor: every accepted output row is checked against the queue head.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_row: got row %0d expected none", out_row_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_d("data", data_out_o, e.data);
                chk("row", 32'(out_row_o), 32'(e.row));
                chk("last", 32'(out_last_o), 32'(e.row == 3'd7));
                chk("sat", 32'(sat_o), 32'(e.sat));
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; cfg_we_i = 1'b0; out_ready_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        sb.delete();
        rst_i = 1'b0;
    endtask

    task automatic send_row(input logic [DW-1:0] d, input logic sel, input exp_t e);
        logic rdy;
        data_in_i = d; tbl_sel_i = sel; in_valid_i = 1'b1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk_i);
            rdy = in_ready_o;
            @(posedge clk_i);
            if (rdy) begin
                sb.push_back(e);
                #1;
                in_valid_i = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk_i);
            w++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        #1;
    endtask

    // Row r of the column-0 ramp, optionally with a table select.
    task automatic ramp_row(input int r, input logic sel, input int expv);
        send_row(xin('0, 0, q_col0[r] * (r + 1) * F), sel, mk(qv('0, 0, expv), r, '0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [QW-1:0] q;
        logic [QW-1:0] held;
        logic [2:0] hrow;

        rst_i = 1'b1; in_valid_i = 1'b0; tbl_sel_i = 1'b0; out_ready_i = 1'b1;
        data_in_i = '0; cfg_we_i = 1'b0; cfg_tbl_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;

        // Reset state and ready immediately after release.
        do_reset();
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk_d("rst_data", data_out_o, '0);
        chk("rst_row", 32'(out_row_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_sat", 32'(sat_o), 32'd0);

        // Basic luma row 0 with latency check; several lanes hand-computed.
        d = xin('0, 0, 32 * F); d = xin(d, 1, 110 * F); d = xin(d, 2, -55 * F); d = xin(d, 7, 61 * F);
        q = qv('0, 0, 2); q = qv(q, 1, 10); q = qv(q, 2, -6); q = qv(q, 7, 1);
        send_row(d, 1'b0, mk(q, 0, '0));
        @(negedge clk_i);
        chk("latency_1", 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        chk("latency_2", 32'(out_valid_o), 32'd1);
        drain();

        // Half rounds away from zero on negative input.
        do_reset();
        send_row(xin('0, 0, -24 * F), 1'b0, mk(qv('0, 0, -2), 0, '0));
        drain();
        do_reset();
        send_row(xin('0, 0, -23 * F), 1'b0, mk(qv('0, 0, -1), 0, '0));
        drain();

        // Table write in the acceptance cycle uses the old entry; later rows saturate.
        do_reset();
        cfg_we_i = 1'b1; cfg_tbl_i = 1'b0; cfg_addr_i = 6'd0; cfg_data_i = 17'd65536;
        send_row(xin('0, 0, 32 * F), 1'b0, mk(qv('0, 0, 2), 0, '0));
        cfg_addr_i = 6'd1; cfg_data_i = 17'd131071;
        @(posedge clk_i);
        #1;
        cfg_we_i = 1'b0;
        for (int r = 1; r < 8; r++) send_row('0, 1'b0, mk('0, r, '0));
        d = xin('0, 0, 32'h7FFFFFFF); d = xin(d, 1, 32'h80000000);
        q = qv('0, 0, 16'h7FFF); q = qv(q, 1, 16'h8000);
        send_row(d, 1'b0, mk(q, 0, 8'b0000_0011));
        drain();

        // Back-to-back block with a three-cycle downstream stall.
        do_reset();
        fork
            begin
                for (int r = 0; r < 8; r++) ramp_row(r, 1'b0, r + 1);
            end
            begin
                repeat (4) @(posedge clk_i);
                #1;
                out_ready_i = 1'b0;
                @(negedge clk_i);
                held = data_out_o;
                hrow = out_row_o;
                chk("stall_valid", 32'(out_valid_o), 32'd1);
                chk("stall_ready", 32'(in_ready_o), 32'd0);
                repeat (2) begin
                    @(negedge clk_i);
                    chk("stall_ready", 32'(in_ready_o), 32'd0);
                    chk_d("stall_hold_data", data_out_o, held);
                    chk("stall_hold_row", 32'(out_row_o), 32'(hrow));
                end
                @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
        join
        drain();

        // Mid-block select change is ignored; next block picks chroma.
        do_reset();
        for (int r = 0; r < 8; r++) ramp_row(r, (r >= 3), r + 1);
        send_row(xin('0, 0, 200 * F), 1'b1, mk(qv('0, 0, 12), 0, '0));
        send_row(xin('0, 0, 24 * F), 1'b0, mk(qv('0, 0, 1), 1, '0));
        drain();

        // Reset mid-block discards in-flight rows and restarts the row counter.
        do_reset();
        for (int r = 0; r < 5; r++) ramp_row(r, 1'b0, r + 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        sb.delete();
        @(negedge clk_i);
        chk("midrst_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_row", 32'(out_row_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("midrst_ready", 32'(in_ready_o), 32'd1);
        send_row(xin('0, 0, 32 * F), 1'b0, mk(qv('0, 0, 2), 0, '0));
        drain();

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
